kit_io_bridge: RTL
==================

// Module: kit_io_bridge
// PURPOSE
//  Parametrised CPU-side bus bridge for the kit top level. Decodes CPU accesses into RAM or a memory-mapped I/O page.
//  The I/O page holds the LED register, the keyboard latch, a buffered VGA write FIFO and a status word.
//  Adds a req/ack handshake with RAM wait states and VGA back-pressure in place of direct point-to-point wiring.
// PARAMETERS
//  DATA_W       16       CPU/RAM data width (min 12, so status fields fit)
//  ADDR_W       16       CPU/RAM address width
//  IO_BASE      16'hFF00 base of 256-word I/O page; addr[ADDR_W-1:8]==IO_BASE[ADDR_W-1:8] selects I/O, else RAM
//  RAM_WAIT     1        RAM read latency in clocks after registered address (>=1)
//  VGA_DEPTH    8        VGA FIFO entries, power of 2, 2..64
//  TIMEOUT_CYC  255      VGA stall limit (used only with KIT_BUS_TIMEOUT_EN)
// PORTS
//  clock        in   1       single system clock, all logic rising-edge
//  reset        in   1       synchronous, active-high
//  cpu_req      in   1       access request, held until cpu_ack
//  cpu_rw       in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr     in   ADDR_W  access address; stable while cpu_req
//  cpu_wdata    in   DATA_W  write data; stable while cpu_req
//  cpu_rdata    out  DATA_W  read data, valid in the cpu_ack cycle
//  cpu_ack      out  1       one-cycle completion pulse
//  cpu_err      out  1       pulses with cpu_ack on a timed-out access
//  ram_addr     out  ADDR_W  registered RAM address
//  ram_wdata    out  DATA_W  registered RAM write data
//  ram_we       out  1       one-cycle RAM write strobe
//  ram_rdata    in   DATA_W  RAM read data
//  kbd_strobe   in   1       one-cycle pulse: new key on kbd_code
//  kbd_code     in   8       key code
//  vga_valid    out  1       FIFO head valid (video flag)
//  vga_ready    in   1       video sink accepts head when valid&ready
//  vga_pos      out  DATA_W  FIFO head position
//  vga_char     out  DATA_W  FIFO head character
//  leds         out  DATA_W  LED register
// BEHAVIOUR
//  Reset: state IDLE, FIFO emptied, cpu_ack=0, cpu_err=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0, leds=0,
//   pos latch=0, kbd latch/valid=0, vga_valid=0. Reset mid-access aborts it with no ack.
//  FSM: IDLE, RAM_WAIT, IO_ACK, VGA_STALL. A request is accepted only in IDLE with cpu_ack=0.
//   Accept cycle k: RAM target -> ram_addr/ram_wdata registered, ram_we=rw at k+1, RAM_WAIT.
//   RAM_WAIT counts RAM_WAIT cycles; ack at k+1+RAM_WAIT; read captures ram_rdata into cpu_rdata.
//   I/O target -> IO_ACK, ack at k+1; write side effects occur at the same edge as the ack.
//  I/O map (offset from IO_BASE):
//   0 LED: R/W.
//   1 KBD: R = {0,kbd_code}; a read clears kbd valid. kbd_strobe reloads code and sets valid.
//     If strobe and read coincide, strobe wins: valid stays 1 with the new code.
//   2 VGA_POS: W latches pos; R returns pos.
//   3 VGA_CHAR: W pushes {pos,wdata} to the FIFO. If the FIFO is full -> VGA_STALL; push+ack on the first non-full cycle.
//   4 STATUS: R = {.., cnt[11:4], bit3 timeout_sticky, bit2 kbd_valid, bit1 empty, bit0 full}.
//     A STATUS read clears the sticky bit. cnt bits above bit 11 are dropped.
//   Other offsets: read 0, write ignored, ack at k+1.
//  FIFO: pop on vga_valid&vga_ready. Push and pop in the same cycle leave the count unchanged.
//   A pop while full does not admit the stalled push in that cycle; the push happens next cycle.
//   Pointers wrap mod VGA_DEPTH. Count is $clog2(VGA_DEPTH)+1 bits.
//  cpu_rdata holds its last value between acks. Writes leave cpu_rdata unchanged.
// CONFIGURATION
//  KIT_BUS_TIMEOUT_EN defined: in VGA_STALL a counter runs; at TIMEOUT_CYC stall cycles the push is dropped.
//   The bridge then acks with cpu_err=1 and sets timeout_sticky.
//  Not defined: cpu_err tied 0, status bit3 reads 0, VGA_STALL waits indefinitely.
// TESTING
//  1 Reset mid-RAM read (reset at k+1) -> no ack ever; after release all outputs hold reset values.
//  2 RAM_WAIT=1: write 0x1234 @0x0010 at k -> ram_we=1 at k+1, ack at k+2.
//    Read @0x0010 -> ack at k+2, cpu_rdata=0x1234.
//  3 Write 0xA5A5 @0xFF00 -> ack at k+1, leds=0xA5A5. Read @0xFF00 -> 0xA5A5.
//    Read @0xFF7F -> 0, leds unchanged.
//  4 kbd_strobe code 0x41 -> STATUS bit2=1. Read @0xFF01 -> 0x0041, then STATUS bit2=0.
//    Strobe coincident with the read -> bit2 stays 1 with the new code.
//  5 vga_ready=0, POS=5, 8 CHAR writes 0x30..0x37 -> STATUS=0x0081.
//    9th write stalls with no ack. Raise vga_ready -> heads (5,0x30)...(5,0x37) in order; 9th acks one cycle after the first pop.
//  6 KIT_BUS_TIMEOUT_EN, TIMEOUT_CYC=16, FIFO full, vga_ready=0 -> ack+cpu_err at stall cycle 16.
//    STATUS bit3=1; the second STATUS read shows 0.

Source files
------------

// File: rtl/kit_io_bridge.sv
// rtl/kit_io_bridge.sv - CPU bus bridge decoding RAM and an I/O page (LED, keyboard, VGA FIFO, status).
// Optional KIT_BUS_TIMEOUT_EN: VGA stall timeout with cpu_err and a sticky status bit.
module kit_io_bridge #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFF00,
    parameter int                RAM_WAIT    = 1,
    parameter int                VGA_DEPTH   = 8,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              kbd_strobe,
    input  logic [7:0]        kbd_code,
    output logic              vga_valid,
    input  logic              vga_ready,
    output logic [DATA_W-1:0] vga_pos,
    output logic [DATA_W-1:0] vga_char,
    output logic [DATA_W-1:0] leds
);

    localparam int PTR_W  = $clog2(VGA_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(RAM_WAIT + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

`ifdef KIT_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [7:0] OFF_LED    = 8'd0;
    localparam logic [7:0] OFF_KBD    = 8'd1;
    localparam logic [7:0] OFF_POS    = 8'd2;
    localparam logic [7:0] OFF_CHAR   = 8'd3;
    localparam logic [7:0] OFF_STATUS = 8'd4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAM_WAIT  = 2'd1,
        S_IO_ACK    = 2'd2,
        S_VGA_STALL = 2'd3
    } state_t;

    state_t state, state_n;

    logic [WAIT_W-1:0] wait_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_sticky;
    logic [DATA_W-1:0] pos_q;
    logic [7:0]        kbd_q;
    logic              kbd_valid;

    logic [DATA_W-1:0] fifo_pos  [VGA_DEPTH];
    logic [DATA_W-1:0] fifo_char [VGA_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              full, empty, push, pop;

    logic              is_io;
    logic [7:0]        io_off;
    logic [DATA_W-1:0] io_rdata, status;
    logic              wait_done, tmo_hit;

    logic              ack_n, err_n, ram_load, io_acc, tmo_set;
    logic [DATA_W-1:0] rdata_n;
    logic              led_wr, pos_wr, kbd_rd, stat_rd;

    assign is_io     = (cpu_addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
    assign io_off    = cpu_addr[7:0];
    assign full      = (fifo_cnt == CNT_W'(VGA_DEPTH));
    assign empty     = (fifo_cnt == '0);
    assign vga_valid = !empty;
    assign vga_pos   = fifo_pos[rd_ptr];
    assign vga_char  = fifo_char[rd_ptr];
    assign pop       = vga_valid && vga_ready;
    assign wait_done = (wait_cnt == WAIT_W'(RAM_WAIT - 1));
    assign tmo_hit   = TMO_EN && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    assign led_wr  = io_acc &&  cpu_rw && (io_off == OFF_LED);
    assign pos_wr  = io_acc &&  cpu_rw && (io_off == OFF_POS);
    assign kbd_rd  = io_acc && !cpu_rw && (io_off == OFF_KBD);
    assign stat_rd = io_acc && !cpu_rw && (io_off == OFF_STATUS);

    always_comb begin
        status = '0;
        status[0] = full;
        status[1] = empty;
        status[2] = kbd_valid;
        status[3] = tmo_sticky;
        status[4 +: CNT_W] = fifo_cnt;
    end

    always_comb begin
        io_rdata = '0;
        case (io_off)
            OFF_LED:    io_rdata = leds;
            OFF_KBD:    io_rdata = DATA_W'(kbd_q);
            OFF_POS:    io_rdata = pos_q;
            OFF_STATUS: io_rdata = status;
            default:    io_rdata = '0;
        endcase
    end

    // A new request is taken only while cpu_ack is low, so a held cpu_req is not re-accepted.
    always_comb begin
        state_n  = state;
        ack_n    = 1'b0;
        err_n    = 1'b0;
        rdata_n  = cpu_rdata;
        ram_load = 1'b0;
        io_acc   = 1'b0;
        push     = 1'b0;
        tmo_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req && !cpu_ack) begin
                    if (!is_io) begin
                        state_n  = S_RAM_WAIT;
                        ram_load = 1'b1;
                    end else if (cpu_rw && (io_off == OFF_CHAR) && full) begin
                        state_n = S_VGA_STALL;
                    end else begin
                        state_n = S_IO_ACK;
                        ack_n   = 1'b1;
                        io_acc  = 1'b1;
                        if (!cpu_rw) rdata_n = io_rdata;
                        if (cpu_rw && (io_off == OFF_CHAR)) push = 1'b1;
                    end
                end
            end
            S_RAM_WAIT: begin
                if (wait_done) begin
                    state_n = S_IDLE;
                    ack_n   = 1'b1;
                    if (!cpu_rw) rdata_n = ram_rdata;
                end
            end
            S_IO_ACK: state_n = S_IDLE;
            S_VGA_STALL: begin
                // full is registered: a pop in this cycle frees the slot for the next one.
                if (!full) begin
                    push    = 1'b1;
                    ack_n   = 1'b1;
                    state_n = S_IO_ACK;
                end else if (tmo_hit) begin
                    ack_n   = 1'b1;
                    err_n   = 1'b1;
                    tmo_set = 1'b1;
                    state_n = S_IO_ACK;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_ack    <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            wait_cnt   <= '0;
            tmo_cnt    <= '0;
            tmo_sticky <= 1'b0;
            leds       <= '0;
            pos_q      <= '0;
            kbd_q      <= '0;
            kbd_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            cpu_ack   <= ack_n;
            cpu_err   <= err_n;
            cpu_rdata <= rdata_n;
            ram_we    <= ram_load && cpu_rw;
            if (ram_load) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end
            wait_cnt <= (state == S_RAM_WAIT) ? wait_cnt + 1'b1 : '0;
            tmo_cnt  <= (state == S_VGA_STALL) ? tmo_cnt + 1'b1 : '0;
            if (tmo_set) begin
                tmo_sticky <= 1'b1;
            end else if (stat_rd) begin
                tmo_sticky <= 1'b0;
            end
            if (led_wr) leds  <= cpu_wdata;
            if (pos_wr) pos_q <= cpu_wdata;
            // A strobe on the same edge as a keyboard read keeps the new key pending.
            if (kbd_strobe) begin
                kbd_q     <= kbd_code;
                kbd_valid <= 1'b1;
            end else if (kbd_rd) begin
                kbd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pos[wr_ptr]  <= pos_q;
            fifo_char[wr_ptr] <= cpu_wdata;
        end
    end

endmodule
